uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 132 +++++++++++++
 tb/tb_uart_tx_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among four byte requesters.
// Owns the transmitter from grant through the stop bit plus one guard cycle.
module uart_tx_sched #(
    parameter int dataBits   = 8,
    parameter int frameTicks = 160,
    parameter int nReq       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sTick,
    input  logic [nReq-1:0]          reqValid,
    input  logic [nReq*dataBits-1:0] reqData,
    output logic [nReq-1:0]          reqAck,
    output logic                     txStart,
    input  logic                     txDoneTick,
    output logic [dataBits-1:0]      txData,
    output logic [1:0]               grantId,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_TICK = 8'(frameTicks - 1);

    state_t                r_state,     w_state;
    logic [nReq-1:0]       r_reqAck,    w_reqAck;
    logic                  r_txStart,   w_txStart;
    logic [dataBits-1:0]   r_txData,    w_txData;
    logic [1:0]            r_grantId,   w_grantId;
    logic [1:0]            r_lastGrant, w_lastGrant;
    logic [7:0]            r_tickCnt,   w_tickCnt;

    logic                  w_anyReq;
    logic [1:0]            w_winner;

    // Scan from the largest offset down so the nearest requester after lastGrant wins;
    // the 2-bit index sum wraps modulo four on its own.
    always_comb begin
        w_anyReq = 1'b0;
        w_winner = r_lastGrant;
        for (int k = nReq; k >= 1; k--) begin
            if (reqValid[r_lastGrant + 2'(k)]) begin
                w_anyReq = 1'b1;
                w_winner = r_lastGrant + 2'(k);
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
    always_comb begin
        w_state     = r_state;
        w_reqAck    = '0;
        w_txStart   = 1'b0;
        w_txData    = r_txData;
        w_grantId   = r_grantId;
        w_lastGrant = r_lastGrant;
        w_tickCnt   = r_tickCnt;

        case (r_state)
            S_IDLE: begin
                if (w_anyReq) begin
                    w_state            = S_LAUNCH;
                    w_txStart          = 1'b1;
                    w_reqAck[w_winner] = 1'b1;
                    w_txData           = reqData[w_winner*dataBits +: dataBits];
                    w_grantId          = w_winner;
                    w_lastGrant        = w_winner;
                end
            end
            S_LAUNCH: begin
                // An sTick coinciding with acceptance belongs to the start bit already under way.
                if (txDoneTick) begin
                    w_state   = S_FRAME;
                    w_tickCnt = 8'd0;
                end else begin
                    w_txStart = 1'b1;
                end
            end
            S_FRAME: begin
                if (sTick) begin
                    w_tickCnt = r_tickCnt + 8'd1;
                    if (r_tickCnt == LAST_TICK) begin
                        w_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_reqAck    <= '0;
            r_txStart   <= 1'b0;
            r_txData    <= '0;
            r_grantId   <= 2'd0;
            r_lastGrant <= 2'd3;
            r_tickCnt   <= 8'd0;
        end else begin
            r_state     <= w_state;
            r_reqAck    <= w_reqAck;
            r_txStart   <= w_txStart;
            r_txData    <= w_txData;
            r_grantId   <= w_grantId;
            r_lastGrant <= w_lastGrant;
            r_tickCnt   <= w_tickCnt;
        end
    end

    assign reqAck  = r_reqAck;
    assign txStart = r_txStart;
    assign txData  = r_txData;
    assign grantId = r_grantId;
    assign busy    = (r_state != S_IDLE);

    a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(reqAck));
    a_start_in_launch: assert property (@(posedge clk) disable iff (reset)
        txStart == (r_state == S_LAUNCH));

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of grant vectors, each run through a full frame,
// plus hand-written reset-mid-frame and post-reset sequences.
module tb_uart_tx_sched;

    logic        clk;
    logic        reset;
    logic        sTick;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqAck;
    logic        txStart;
    logic        txDoneTick;
    logic [7:0]  txData;
    logic [1:0]  grantId;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_sched #(.dataBits(8), .frameTicks(160), .nReq(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sTick      (sTick),
        .reqValid   (reqValid),
        .reqData    (reqData),
        .reqAck     (reqAck),
        .txStart    (txStart),
        .txDoneTick (txDoneTick),
        .txData     (txData),
        .grantId    (grantId),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_data;
        int          launch_delay;
        bit          coincide;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, then drive the frame: grant, delayed acceptance, 160 ticks, guard cycle.
    task automatic run_frame(input vec_t v, input string tag);
        int bad_launch = 0;
        int bad_frame  = 0;
        int bad_data   = 0;
        int high_cnt   = 0;
        logic [3:0] ack_exp;
        ack_exp    = 4'b0001 << v.exp_grant;
        reqValid   = v.valid;
        reqData    = v.data;
        sTick      = 1'b0;
        txDoneTick = 1'b0;
        step();
        check({tag, "_ack"},     32'(reqAck),  32'(ack_exp));
        check({tag, "_grant"},   32'(grantId), 32'(v.exp_grant));
        check({tag, "_txdata"},  32'(txData),  32'(v.exp_data));
        check({tag, "_busy_on"}, 32'(busy),    32'd1);
        if (txStart === 1'b1) high_cnt++;
        // Granted requester withdraws and scribbles over its data; others keep waiting.
        reqValid = v.valid & ~ack_exp;
        reqData  = ~v.data;
        for (int k = 0; k < v.launch_delay; k++) begin
            sTick = k[0];
            step();
            if (reqAck !== 4'b0000) bad_launch++;
            if (txStart === 1'b1) high_cnt++;
            if (txData !== v.exp_data) bad_data++;
        end
        txDoneTick = 1'b1;
        sTick      = v.coincide;
        step();
        txDoneTick = 1'b0;
        sTick      = 1'b0;
        check({tag, "_txstart_cycles"}, 32'(high_cnt), 32'(v.launch_delay + 1));
        check({tag, "_txstart_drop"},   32'(txStart),  32'd0);
        check({tag, "_ack_one_clk"},    32'(reqAck),   32'd0);
        check({tag, "_launch_ack"},     32'(bad_launch), 32'd0);
        for (int n = 1; n < 160; n++) begin
            sTick = 1'b1;
            step();
            if (busy !== 1'b1 || txStart !== 1'b0 || reqAck !== 4'b0000) bad_frame++;
            if (txData !== v.exp_data) bad_data++;
            sTick      = 1'b0;
            txDoneTick = (n == 77);
            step();
            txDoneTick = 1'b0;
            if (busy !== 1'b1 || txStart !== 1'b0 || reqAck !== 4'b0000) bad_frame++;
            if (txData !== v.exp_data) bad_data++;
        end
        check({tag, "_frame_hold"}, 32'(bad_frame), 32'd0);
        sTick = 1'b1;
        step();
        sTick = 1'b0;
        check({tag, "_gap_busy"},   32'(busy),   32'd1);
        check({tag, "_gap_txdata"}, 32'(txData), 32'(v.exp_data));
        step();
        check({tag, "_idle_busy"},    32'(busy),     32'd0);
        check({tag, "_idle_txstart"}, 32'(txStart),  32'd0);
        check({tag, "_data_stable"},  32'(bad_data), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t last;
        //           valid    data          grant  byte   delay coincide
        vecs[0] = '{4'b0001, 32'h1122_33A5, 2'd0, 8'hA5,  2, 1'b0};
        vecs[1] = '{4'b1111, 32'h4433_2211, 2'd1, 8'h22, 20, 1'b0};
        vecs[2] = '{4'b1111, 32'h8877_6655, 2'd2, 8'h77,  1, 1'b1};
        vecs[3] = '{4'b1111, 32'hCCBB_AA99, 2'd3, 8'hCC,  3, 1'b1};
        vecs[4] = '{4'b1111, 32'h0F0E_0D0C, 2'd0, 8'h0C,  0, 1'b0};
        vecs[5] = '{4'b1001, 32'hDEAD_BEEF, 2'd3, 8'hDE,  1, 1'b0};
        vecs[6] = '{4'b0110, 32'h1234_5678, 2'd1, 8'h56,  1, 1'b0};
        vecs[7] = '{4'b0100, 32'h00FF_0000, 2'd2, 8'hFF,  1, 1'b0};
        vecs[8] = '{4'b0011, 32'h5A5A_5A3C, 2'd0, 8'h3C,  1, 1'b0};

        reset      = 1'b1;
        sTick      = 1'b0;
        txDoneTick = 1'b0;
        reqValid   = 4'b0000;
        reqData    = 32'h0;
        step();
        step();
        check("rst_txstart", 32'(txStart), 32'd0);
        check("rst_ack",     32'(reqAck),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_txdata",  32'(txData),  32'd0);
        check("rst_grant",   32'(grantId), 32'd0);
        #2 reset = 1'b0;

        // Stray acceptance pulses in IDLE must not start anything.
        txDoneTick = 1'b1;
        sTick      = 1'b1;
        step();
        step();
        txDoneTick = 1'b0;
        sTick      = 1'b0;
        check("idle_stray_busy",    32'(busy),    32'd0);
        check("idle_stray_txstart", 32'(txStart), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of a frame owned by requester 2.
        reqValid = 4'b0100;
        reqData  = 32'h00AB_0000;
        step();
        check("mid_ack",    32'(reqAck), 32'h4);
        check("mid_txdata", 32'(txData), 32'hAB);
        reqValid   = 4'b0000;
        txDoneTick = 1'b1;
        step();
        txDoneTick = 1'b0;
        for (int n = 0; n < 50; n++) begin
            sTick = 1'b1;
            step();
            sTick = 1'b0;
            step();
        end
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_txstart", 32'(txStart), 32'd0);
        check("mid_rst_busy",    32'(busy),    32'd0);
        check("mid_rst_ack",     32'(reqAck),  32'd0);
        check("mid_rst_txdata",  32'(txData),  32'd0);
        check("mid_rst_grant",   32'(grantId), 32'd0);
        step();
        #2 reset = 1'b0;
        step();
        step();
        check("post_rst_no_reack", 32'(reqAck), 32'd0);
        check("post_rst_idle",     32'(busy),   32'd0);

        // Grant on the very first edge after reset release goes to requester 0.
        reset = 1'b1;
        #3 reset = 1'b0;
        last = '{4'b1111, 32'hF0E1_D2C3, 2'd0, 8'hC3, 0, 1'b0};
        run_frame(last, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
